// File: rtl/ccff_prog_pkg.sv
// rtl/ccff_prog_pkg.sv - shared types, CRC constants and sizing helper for the ccff programming controller.
package ccff_prog_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_VERIFY,
      ST_DONE
   } state_t;

   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   function automatic int num_words(input int chain_len, input int word_w);
      return (chain_len + word_w - 1) / word_w;
   endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// rtl/ccff_crc16_serial.sv - bit-serial CRC-16-CCITT accumulator with clear and enable.
module ccff_crc16_serial
   import ccff_prog_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic        din,
   output logic [15:0] crc
);

   logic [15:0] crc_q, crc_d;
   logic        fb;

   always_comb begin
      fb    = din ^ crc_q[15];
      crc_d = crc_q;
      if (clr) begin
         crc_d = CRC16_INIT;
      end else if (en) begin
         crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         crc_q <= CRC16_INIT;
      end else begin
         crc_q <= crc_d;
      end
   end

   assign crc = crc_q;

endmodule

// File: rtl/ccff_prog_ctrl.sv
// rtl/ccff_prog_ctrl.sv - ccff chain programming controller: word stream in, MSB-first serial out.
// Defining CCFF_READBACK_EN adds a recirculating CRC readback check (VERIFY state, error flag).
module ccff_prog_ctrl
   import ccff_prog_pkg::*;
#(
   parameter int CHAIN_LEN = 64,
   parameter int WORD_W    = 8
) (
   input  logic              prog_clk,
   input  logic              prog_reset,
   input  logic              start,
   input  logic [WORD_W-1:0] bs_data,
   input  logic              bs_valid,
   output logic              bs_ready,
   output logic              ccff_head,
   input  logic              ccff_tail,
   output logic              chain_clk_en,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int NUM_WORDS = num_words(CHAIN_LEN, WORD_W);
   localparam int BCW       = $clog2(CHAIN_LEN + 1);
   localparam int WCW       = $clog2(NUM_WORDS + 1);
   localparam int SCW       = $clog2(WORD_W + 1);

   state_t            state_q, state_d;
   logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [WCW-1:0]    word_cnt_q, word_cnt_d;
   logic [WORD_W-1:0] buf_q, buf_d, sh_q, sh_d, src;
   logic              buf_full_q, buf_full_d;
   logic [SCW-1:0]    sh_cnt_q, sh_cnt_d, src_cnt;
   logic              head_q, head_d, en_q, en_d;
   logic              load_sh, pop, take, pass_start, last_verify;

   assign pass_start = (state_q == ST_IDLE) && start;
   assign take       = bs_valid && bs_ready;

   // An empty shifter is refilled from the buffer in the same cycle it pops, so streams have no bubble.
   always_comb begin
      load_sh = (state_q == ST_SHIFT) && (sh_cnt_q == '0) && buf_full_q;
      src     = load_sh ? buf_q : sh_q;
      src_cnt = load_sh ? SCW'(WORD_W) : sh_cnt_q;
      pop     = (state_q == ST_SHIFT) && (src_cnt != '0);
   end

`ifdef CCFF_READBACK_EN
   logic [BCW-1:0] vcnt_q, vcnt_d;
   logic           error_q, error_d, recirc, crc_mismatch;
   logic [15:0]    crc_head, crc_tail;

   ccff_crc16_serial u_crc_head (
      .clk (prog_clk), .rst (prog_reset), .clr (pass_start),
      .en  (pop), .din (src[WORD_W-1]), .crc (crc_head)
   );
   ccff_crc16_serial u_crc_tail (
      .clk (prog_clk), .rst (prog_reset), .clr (pass_start),
      .en  (recirc), .din (ccff_tail), .crc (crc_tail)
   );

   // First VERIFY cycle still carries the final loaded bit; recirculation follows for CHAIN_LEN cycles.
   assign recirc       = (state_q == ST_VERIFY) && (vcnt_q != '0);
   assign last_verify  = (vcnt_q == BCW'(CHAIN_LEN));
   assign crc_mismatch = (state_q == ST_DONE) && (crc_head != crc_tail);

   always_comb begin
      vcnt_d  = vcnt_q;
      error_d = error_q;
      if (pass_start) begin
         vcnt_d  = '0;
         error_d = 1'b0;
      end else if (state_q == ST_VERIFY) begin
         vcnt_d = vcnt_q + BCW'(1);
      end else if (state_q == ST_DONE) begin
         error_d = error_q || crc_mismatch;
      end
   end

   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         vcnt_q  <= '0;
         error_q <= 1'b0;
      end else begin
         vcnt_q  <= vcnt_d;
         error_q <= error_d;
      end
   end
`else
   logic unused_tail;
   assign unused_tail = ccff_tail;
   assign last_verify = 1'b0;
`endif

   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_SHIFT;
         ST_SHIFT:
            if (pop && (bit_cnt_q == BCW'(CHAIN_LEN - 1))) begin
`ifdef CCFF_READBACK_EN
               state_d = ST_VERIFY;
`else
               state_d = ST_DONE;
`endif
            end
         ST_VERIFY: if (last_verify) state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      bit_cnt_d  = bit_cnt_q;
      word_cnt_d = word_cnt_q;
      buf_d      = buf_q;
      buf_full_d = buf_full_q;
      sh_d       = sh_q;
      sh_cnt_d   = sh_cnt_q;
      head_d     = pop ? src[WORD_W-1] : head_q;
      en_d       = pop;
      if (pass_start) begin
         bit_cnt_d  = '0;
         word_cnt_d = '0;
         buf_d      = '0;
         buf_full_d = 1'b0;
         sh_d       = '0;
         sh_cnt_d   = '0;
      end else if (state_q == ST_SHIFT) begin
         sh_d     = src;
         sh_cnt_d = src_cnt;
         if (load_sh) buf_full_d = 1'b0;
         if (pop) begin
            sh_d      = src << 1;
            sh_cnt_d  = src_cnt - SCW'(1);
            bit_cnt_d = bit_cnt_q + BCW'(1);
         end
         if (take) begin
            buf_d      = bs_data;
            buf_full_d = 1'b1;
            word_cnt_d = word_cnt_q + WCW'(1);
         end
      end
   end

   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         bit_cnt_q  <= '0;
         word_cnt_q <= '0;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
         sh_q       <= '0;
         sh_cnt_q   <= '0;
         head_q     <= 1'b0;
         en_q       <= 1'b0;
      end else begin
         bit_cnt_q  <= bit_cnt_d;
         word_cnt_q <= word_cnt_d;
         buf_q      <= buf_d;
         buf_full_q <= buf_full_d;
         sh_q       <= sh_d;
         sh_cnt_q   <= sh_cnt_d;
         head_q     <= head_d;
         en_q       <= en_d;
      end
   end

   always_comb begin
      busy     = (state_q == ST_SHIFT) || (state_q == ST_VERIFY);
      done     = (state_q == ST_DONE);
      bs_ready = (state_q == ST_SHIFT) && !buf_full_q && (word_cnt_q < WCW'(NUM_WORDS));
`ifdef CCFF_READBACK_EN
      chain_clk_en = en_q || recirc;
      ccff_head    = recirc ? ccff_tail : head_q;
      error        = error_q || crc_mismatch;
`else
      chain_clk_en = en_q;
      ccff_head    = head_q;
      error        = 1'b0;
`endif
   end

endmodule
